ahb_apb_bridge: RTL and testbench
=================================

# ahb_apb_bridge

AHB-Lite to APB bridge acting as the APB initiator for the peripheral subsystem. Accepts single AHB-Lite transfers, decodes a slave index from the address, and runs one APB SETUP/ACCESS sequence on the selected peripheral. It returns read data, wait states and PSLVERR-derived errors to AHB. The AHB and APB sides share one clock, so there is no clock-domain crossing.

## Interface
Parameters:
- NUM_SLV, 16: number of APB slaves; legal range 1–16.
- PAW, 16: PADDR width; PADDR = HADDR[PAW-1:0].

Ports:
- PCLK  in  1  clock, shared by AHB and APB sides.
- PRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  bridge select.
- HADDR  in  32  address. HADDR[23:20] is the slave index.
- HTRANS  in  2  transfer type. Only bit 1 is used (NONSEQ/SEQ = valid).
- HWRITE  in  1  write flag.
- HREADY  in  1  bus-wide ready.
- HWDATA  in  32  write data.
- HREADYOUT  out  1  bridge ready.
- HRESP  out  1  1 = ERROR.
- HRDATA  out  32  read data.
- PADDR  out  PAW  APB address, registered.
- PSEL  out  NUM_SLV  one-hot slave select, registered.
- PENABLE  out  1  access phase, registered.
- PWRITE  out  1  registered write flag.
- PWDATA  out  32  equals HWDATA (held stable by AHB during the stalled data phase).
- PRDATA  in  32*NUM_SLV  slave read data, flattened; slave i occupies [32i+31:32i].
- PREADY  in  NUM_SLV  per-slave ready.
- PSLVERR  in  NUM_SLV  per-slave error.

## Operation
- Transfer accept:
  - Condition: `accept = HSEL & HTRANS[1] & HREADY`, evaluated in IDLE, in ACCESS on its completing cycle, and in ERR2.
  - On accept, register HADDR[PAW-1:0], HWRITE and slave index `idx`.
  - HSIZE, HBURST and HPROT are ignored; every access is a 32-bit APB access.
- States: IDLE, SETUP, ACCESS, ERR1, ERR2.
  - IDLE: accept & idx<NUM_SLV → SETUP. accept & idx≥NUM_SLV → ERR1, with no APB activity.
  - SETUP: PSEL[idx]=1, PENABLE=0. Always → ACCESS.
  - ACCESS: PSEL[idx]=1, PENABLE=1. Let `sel` be PREADY[idx] and PSLVERR[idx].
    - PREADY=0: stay in ACCESS.
    - PREADY=1 & PSLVERR=1: → ERR1.
    - PREADY=1 & PSLVERR=0: → SETUP if a valid accept is present (back-to-back), else → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL=0. Always → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept evaluated as in IDLE, else → IDLE.
- HREADYOUT:
  - 1 in IDLE and ERR2.
  - 0 in SETUP and ERR1.
  - In ACCESS: PREADY[idx] & ~PSLVERR[idx].
- HRESP: 1 only in ERR1 and ERR2.
- HRDATA: PRDATA slice idx while in ACCESS, 0 otherwise. Purely combinational; no extra latency.
- APB write data: PWDATA is valid from SETUP through the end of ACCESS.
- PSEL/PENABLE at state changes:
  - PSEL deasserts on the cycle after completion unless the next state is SETUP.
  - On back-to-back transfers, PENABLE drops to 0 for the SETUP cycle. PSEL may move to a different slave.
- Reset: an asynchronous reset asserted in any state forces IDLE immediately, mid-transfer included.

## Timing
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, HREADYOUT=1, HRESP=0, HRDATA=0.
- Latency, with address phase at T0:
  - T1 = SETUP.
  - T2 = first ACCESS cycle.
  - With PREADY=1 at T2, the AHB data phase ends at T2: one wait state.
  - Each PREADY=0 cycle in ACCESS adds one wait state.
- Error response:
  - Two cycles, ERR1 then ERR2, following the ACCESS cycle that saw PREADY=1 & PSLVERR=1.
  - For an unmapped index, the two cycles follow the address phase directly.
- Write completion: PSLVERR on a write still produces the AHB error; the slave's register state is the slave's concern.

## Test plan
1. **Single write.** Write 0x12345678 to HADDR 0x0010_0008 with all PREADY=1.
   - T1: PSEL=0x0002, PADDR=0x0008, PWRITE=1, PENABLE=0, HREADYOUT=0.
   - T2: PENABLE=1, HREADYOUT=1, PWDATA=0x12345678.
   - T3: PSEL=0.
2. **Read with wait states.** Read HADDR 0x0030_0004 with PREADY[3]=0 for 2 ACCESS cycles and PRDATA[3]=0xCAFEF00D.
   - HREADYOUT low for 3 cycles.
   - HRDATA=0xCAFEF00D with HRESP=0 in the completing cycle.
3. **Back-to-back.** Write slave 2, then pipelined read of slave 5.
   - ACCESS goes directly to SETUP.
   - PSEL changes 0x0004 → 0x0020 with no idle cycle.
   - PENABLE is 1,0,1 across the boundary.
4. **Slave error.** PSLVERR[1]=1 with PREADY[1]=1 in ACCESS.
   - Next cycle: HREADYOUT=0/HRESP=1.
   - Following cycle: HREADYOUT=1/HRESP=1.
   - Then IDLE with HRESP=0.
5. **Unmapped slave.** NUM_SLV=8, access to HADDR 0x00A0_0000.
   - PSEL stays 0 throughout.
   - Two-cycle ERROR response immediately after the address phase.
6. **Reset mid-transfer.** Assert PRESETn=0 in ACCESS while PREADY=0.
   - PSEL, PENABLE and HRESP go to 0 and HREADYOUT to 1 without waiting for a PCLK edge.
   - After release, a new write completes normally.

Source files
------------

// File: rtl/ahb_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ahb_apb_bridge
// Purpose  : AHB-Lite to APB bridge; APB initiator for the peripheral
//            subsystem. Takes single AHB-Lite transfers, decodes the slave
//            index from HADDR[23:20] and runs one APB SETUP/ACCESS sequence
//            on the selected peripheral. Read data, wait states and
//            PSLVERR-derived ERROR responses are returned to AHB. AHB and
//            APB share PCLK.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_SLV   number of APB slaves (1..16)
//   PAW       PADDR width, PADDR = HADDR[PAW-1:0]
// Ports
//   PCLK, PRESETn              clock, async active-low reset
//   HSEL/HADDR/HTRANS/HWRITE   AHB address phase
//   HREADY/HWDATA              AHB bus ready, write data
//   HREADYOUT/HRESP/HRDATA     AHB response
//   PADDR/PSEL/PENABLE/PWRITE  registered APB control
//   PWDATA                     APB write data (HWDATA passthrough)
//   PRDATA/PREADY/PSLVERR      per-slave APB returns (PRDATA flattened)
// ============================================================================
module ahb_apb_bridge #(
    parameter int NUM_SLV = 16,
    parameter int PAW     = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic                    HREADY,
    input  logic [31:0]             HWDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [31:0]             HRDATA,
    output logic [PAW-1:0]          PADDR,
    output logic [NUM_SLV-1:0]      PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [31:0]             PWDATA,
    input  logic [32*NUM_SLV-1:0]   PRDATA,
    input  logic [NUM_SLV-1:0]      PREADY,
    input  logic [NUM_SLV-1:0]      PSLVERR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_ERR1   = 3'd3,
        S_ERR2   = 3'd4
    } state_t;

    state_t               r_state;
    logic [3:0]           r_idx;
    logic [PAW-1:0]       r_paddr;
    logic                 r_pwrite;
    logic [NUM_SLV-1:0]   r_psel;
    logic                 r_penable;

    logic [3:0]           w_idx;
    logic                 w_accept;
    logic                 w_mapped;
    logic [NUM_SLV-1:0]   w_dec;
    logic                 w_pready;
    logic                 w_pslverr;
    logic [31:0]          w_prdata;
    logic                 w_done;
    logic                 w_take;
    logic                 w_unused;

    assign w_idx    = HADDR[23:20];
    assign w_accept = HSEL & HTRANS[1] & HREADY;
    assign w_mapped = ({1'b0, w_idx} < 5'(NUM_SLV));

    // Only the transfer-valid bit of HTRANS and the decoded address bits
    // matter; the remaining inputs are folded here so they read as used.
    assign w_unused = ^{HADDR, HTRANS[0]};

    // Address decode (incoming transfer) and return-path mux (active slave).
    // Loops keep indexing inside 0..NUM_SLV-1 for every NUM_SLV.
    always_comb begin
        w_dec     = '0;
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_idx == 4'(i)) begin
                w_dec[i] = 1'b1;
            end
            if (r_idx == 4'(i)) begin
                w_pready  = PREADY[i];
                w_pslverr = PSLVERR[i];
                w_prdata  = PRDATA[32*i +: 32];
            end
        end
    end

    // A new transfer may be taken when idle, in ERR2 (HREADYOUT is high
    // there) or on the error-free completing ACCESS cycle (back-to-back).
    assign w_done = (r_state == S_ACCESS) & w_pready & ~w_pslverr;
    assign w_take = w_accept &
                    ((r_state == S_IDLE) | (r_state == S_ERR2) | w_done);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= '0;
            r_penable <= 1'b0;
        end else if (w_take) begin
            r_idx     <= w_idx;
            r_paddr   <= HADDR[PAW-1:0];
            r_pwrite  <= HWRITE;
            r_penable <= 1'b0;
            if (w_mapped) begin
                r_state <= S_SETUP;
                r_psel  <= w_dec;
            end else begin
                // Unmapped slave: error response without touching APB.
                r_state <= S_ERR1;
                r_psel  <= '0;
            end
        end else begin
            case (r_state)
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (w_pready) begin
                        r_state   <= w_pslverr ? S_ERR1 : S_IDLE;
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                    end
                end
                S_ERR1: begin
                    r_state <= S_ERR2;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_psel    <= '0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    // AHB response is decoded from the registered state; only the ACCESS
    // case looks through to the selected slave so no latency is added.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (r_state)
            S_SETUP: begin
                HREADYOUT = 1'b0;
            end
            S_ACCESS: begin
                HREADYOUT = w_pready & ~w_pslverr;
                HRDATA    = w_prdata;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: begin
                HRESP     = 1'b1;
            end
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

    assign PADDR   = r_paddr;
    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PWDATA  = HWDATA;

endmodule
`default_nettype wire

// File: tb/tb_ahb_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_apb_bridge
// Purpose  : Self-checking bench for ahb_apb_bridge (NUM_SLV=8, PAW=16).
//            Directed scenarios plus randomized single transfers; expected
//            cycle-by-cycle behaviour is derived from the transfer's slave
//            index, wait count and error flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_apb_bridge;

    localparam int NS = 8;

    logic              PCLK;
    logic              PRESETn;
    logic              HSEL;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic              HREADY;
    logic [31:0]       HWDATA;
    logic              HREADYOUT;
    logic              HRESP;
    logic [31:0]       HRDATA;
    logic [15:0]       PADDR;
    logic [NS-1:0]     PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [32*NS-1:0]  PRDATA;
    logic [NS-1:0]     PREADY;
    logic [NS-1:0]     PSLVERR;

    int n_cmp = 0;
    int n_bad = 0;

    // Single AHB slave on the bus: bus ready follows the bridge.
    assign HREADY = HREADYOUT;

    ahb_apb_bridge #(.NUM_SLV(NS), .PAW(16)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Randomise every slave's return signals; callers override the slave
    // under test so a wrong return-path select shows up as a data error.
    task automatic rnd_slaves();
        PREADY  = NS'($urandom);
        PSLVERR = NS'($urandom);
        for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge PCLK);
        #2;
    endtask

    // One non-pipelined AHB transfer. Expected timeline:
    //   mapped  : SETUP, (waits+1) ACCESS cycles, [ERR1, ERR2 if err], IDLE
    //   unmapped: ERR1, ERR2, IDLE
    task automatic xfer(input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int waits, input logic err);
        int          idx;
        bit          mapped;
        logic [31:0] onehot;
        bit          last;
        idx    = int'(addr[23:20]);
        mapped = (idx < NS);
        onehot = 32'd1 << idx;

        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
        #1;
        chk("addr_hreadyout", 32'(HREADYOUT), 32'd1);

        next_cycle();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
        rnd_slaves();
        #1;
        if (mapped) begin
            chk("setup_psel",      32'(PSEL),      onehot);
            chk("setup_penable",   32'(PENABLE),   32'd0);
            chk("setup_paddr",     32'(PADDR),     32'(addr[15:0]));
            chk("setup_pwrite",    32'(PWRITE),    32'(wr));
            chk("setup_hreadyout", 32'(HREADYOUT), 32'd0);
            chk("setup_hresp",     32'(HRESP),     32'd0);
            for (int w = 0; w <= waits; w++) begin
                next_cycle();
                last = (w == waits);
                rnd_slaves();
                PRDATA[32*idx +: 32] = rdata;
                PREADY[idx]  = last;
                PSLVERR[idx] = err && last;
                #1;
                chk("access_psel",      32'(PSEL),      onehot);
                chk("access_penable",   32'(PENABLE),   32'd1);
                chk("access_pwdata",    PWDATA,         wdata);
                chk("access_hreadyout", 32'(HREADYOUT), 32'(last && !err));
                chk("access_hrdata",    HRDATA,         rdata);
                chk("access_hresp",     32'(HRESP),     32'd0);
            end
            if (err) begin
                next_cycle();
                rnd_slaves();
                #1;
                chk("err1_hreadyout", 32'(HREADYOUT), 32'd0);
                chk("err1_hresp",     32'(HRESP),     32'd1);
                chk("err1_psel",      32'(PSEL),      32'd0);
                chk("err1_penable",   32'(PENABLE),   32'd0);
            end
        end else begin
            chk("unm_err1_hreadyout", 32'(HREADYOUT), 32'd0);
            chk("unm_err1_hresp",     32'(HRESP),     32'd1);
            chk("unm_err1_psel",      32'(PSEL),      32'd0);
        end
        if (err || !mapped) begin
            next_cycle();
            rnd_slaves();
            #1;
            chk("err2_hreadyout", 32'(HREADYOUT), 32'd1);
            chk("err2_hresp",     32'(HRESP),     32'd1);
            chk("err2_psel",      32'(PSEL),      32'd0);
        end
        next_cycle();
        rnd_slaves();
        #1;
        chk("idle_psel",      32'(PSEL),      32'd0);
        chk("idle_penable",   32'(PENABLE),   32'd0);
        chk("idle_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("idle_hresp",     32'(HRESP),     32'd0);
        chk("idle_hrdata",    HRDATA,         32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          idx;

        PRESETn = 1'b1;
        HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = '0;
        PRDATA = '0; PREADY = '1; PSLVERR = '0;

        // Reset values
        #2 PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #3;
        chk("rst_psel",      32'(PSEL),      32'd0);
        chk("rst_penable",   32'(PENABLE),   32'd0);
        chk("rst_pwrite",    32'(PWRITE),    32'd0);
        chk("rst_paddr",     32'(PADDR),     32'd0);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp",     32'(HRESP),     32'd0);
        chk("rst_hrdata",    HRDATA,         32'd0);
        PRESETn = 1'b1;
        next_cycle();

        // Single write, slave 1
        xfer(32'h0010_0008, 1'b1, 32'h1234_5678, 32'h0BAD_0001, 0, 1'b0);
        // Read with two wait states, slave 3
        xfer(32'h0030_0004, 1'b0, 32'h0, 32'hCAFE_F00D, 2, 1'b0);
        // Slave error, slave 1
        xfer(32'h0010_0000, 1'b1, 32'hDEAD_0001, 32'h0, 0, 1'b1);
        // Unmapped slave index 10
        xfer(32'h00A0_0000, 1'b0, 32'h0, 32'h0, 0, 1'b0);

        // Back-to-back: write slave 2, pipelined read of slave 5
        PREADY = '1; PSLVERR = '0;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0020_000C; HWRITE = 1'b1;
        next_cycle();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hA5A5_0001;
        #1;
        chk("b2b_t1_psel",    32'(PSEL),    32'h04);
        chk("b2b_t1_penable", 32'(PENABLE), 32'd0);
        next_cycle();
        PRDATA[32*5 +: 32] = 32'h5555_AAAA;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0050_0010; HWRITE = 1'b0;
        #1;
        chk("b2b_t2_psel",      32'(PSEL),      32'h04);
        chk("b2b_t2_penable",   32'(PENABLE),   32'd1);
        chk("b2b_t2_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("b2b_t2_pwdata",    PWDATA,         32'hA5A5_0001);
        next_cycle();
        HSEL = 1'b0; HTRANS = 2'b00;
        #1;
        chk("b2b_t3_psel",      32'(PSEL),      32'h20);
        chk("b2b_t3_penable",   32'(PENABLE),   32'd0);
        chk("b2b_t3_pwrite",    32'(PWRITE),    32'd0);
        chk("b2b_t3_paddr",     32'(PADDR),     32'h0010);
        chk("b2b_t3_hreadyout", 32'(HREADYOUT), 32'd0);
        next_cycle();
        #1;
        chk("b2b_t4_psel",      32'(PSEL),      32'h20);
        chk("b2b_t4_penable",   32'(PENABLE),   32'd1);
        chk("b2b_t4_hrdata",    HRDATA,         32'h5555_AAAA);
        chk("b2b_t4_hreadyout", 32'(HREADYOUT), 32'd1);
        next_cycle();
        #1;
        chk("b2b_t5_psel",      32'(PSEL),      32'd0);
        chk("b2b_t5_penable",   32'(PENABLE),   32'd0);

        // Reset asserted mid-ACCESS while PREADY is low
        PREADY = '1; PSLVERR = '0;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0040_0020; HWRITE = 1'b0;
        next_cycle();
        HSEL = 1'b0; HTRANS = 2'b00;
        PREADY[4] = 1'b0;
        next_cycle();
        #1;
        chk("mid_access_penable",   32'(PENABLE),   32'd1);
        chk("mid_access_hreadyout", 32'(HREADYOUT), 32'd0);
        #1;
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_psel",      32'(PSEL),      32'd0);
        chk("mid_rst_penable",   32'(PENABLE),   32'd0);
        chk("mid_rst_hresp",     32'(HRESP),     32'd0);
        chk("mid_rst_hreadyout", 32'(HREADYOUT), 32'd1);
        next_cycle();
        PRESETn = 1'b1;
        PREADY = '1;
        next_cycle();
        xfer(32'h0060_0014, 1'b1, 32'h0F0F_1234, 32'h0, 1, 1'b0);

        // Randomized single transfers, including unmapped indices and errors
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 9);
            a   = {8'h00, 4'(idx), 4'($urandom), 14'($urandom), 2'b00};
            xfer(a, 1'($urandom), $urandom, $urandom,
                 $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
